// File: rtl/ctech_lib_rstb_sequencer.sv
// rtl/ctech_lib_rstb_sequencer.sv - rb synchronizer and staged release of active-low resets
// Assertion of rb clears everything asynchronously; release is synchronized and staged.
`timescale 1ns/1ps
module ctech_lib_rstb_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_RST     = 3,
    parameter int STAGE_DLY   = 8
) (
    input  logic               clk,
    input  logic               rb,
    input  logic               sw_rst_req,
    output logic               sw_rst_ack,
    output logic [NUM_RST-1:0] rst_out_b,
    output logic               rst_done,
    output logic [1:0]         seq_state
);
    localparam int CNT_W = $clog2(STAGE_DLY + 1);
    localparam int IDX_W = $clog2(NUM_RST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_RST - 1);

    typedef enum logic [1:0] {
        S_ASSERT  = 2'd0,
        S_RELEASE = 2'd1,
        S_DONE    = 2'd2,
        S_SWRST   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_RST-1:0]     r_rst_out_b;
    logic                   r_rst_done;
    logic                   r_ack;

    logic                   w_rb_sync;
    logic                   w_cnt_last;
    logic [NUM_RST-1:0]     w_rel_mask;

    // Constant-1 chain: only the rb edge is synchronized, so any rb low pulse restarts it.
    always_ff @(posedge clk or negedge rb) begin
        if (!rb) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_rb_sync  = r_sync[SYNC_STAGES-1];
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_comb begin
        w_rel_mask = '0;
        for (int i = 0; i < NUM_RST; i++) begin
            w_rel_mask[i] = (r_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rb) begin
        if (!rb) begin
            r_state     <= S_ASSERT;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_rst_out_b <= '0;
            r_rst_done  <= 1'b0;
            r_ack       <= 1'b0;
        end else begin
            case (r_state)
                S_ASSERT: begin
                    if (w_rb_sync) begin
                        r_state <= S_RELEASE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end
                end
                S_RELEASE: begin
                    if (w_cnt_last) begin
                        r_rst_out_b <= r_rst_out_b | w_rel_mask;
                        r_cnt       <= '0;
                        r_idx       <= r_idx + IDX_W'(1);
                        if (r_idx == IDX_LAST) begin
                            r_state    <= S_DONE;
                            r_rst_done <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (sw_rst_req) begin
                        r_state     <= S_SWRST;
                        r_rst_out_b <= '0;
                        r_rst_done  <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                S_SWRST: begin
                    // Hold runs to completion even if req drops early; ack then lasts one cycle.
                    if (r_ack) begin
                        if (!sw_rst_req) begin
                            r_ack   <= 1'b0;
                            r_state <= S_RELEASE;
                            r_cnt   <= '0;
                            r_idx   <= '0;
                        end
                    end else if (w_cnt_last) begin
                        r_ack <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_ASSERT;
                end
            endcase
        end
    end

    assign sw_rst_ack = r_ack;
    assign rst_out_b  = r_rst_out_b;
    assign rst_done   = r_rst_done;
    assign seq_state  = r_state;

endmodule

// File: tb/tb_ctech_lib_rstb_sequencer.sv
// tb/tb_ctech_lib_rstb_sequencer.sv - scoreboard bench for ctech_lib_rstb_sequencer
// Expected output transitions are queued with their edge numbers and matched as they occur.
`timescale 1ns/1ps
module tb_ctech_lib_rstb_sequencer;
    logic       clk = 1'b0;
    logic       rb, req, rb1, req1;
    logic       ack, done;
    logic [2:0] rst_b;
    logic [1:0] st;
    logic       ack1, done1;
    logic [0:0] rst_b1;
    logic [1:0] st1;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    logic [6:0] prev = '0;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
    } ev_t;
    ev_t sb_q[$];

    ctech_lib_rstb_sequencer #(.SYNC_STAGES(2), .NUM_RST(3), .STAGE_DLY(8)) u_dut (
        .clk(clk), .rb(rb), .sw_rst_req(req), .sw_rst_ack(ack),
        .rst_out_b(rst_b), .rst_done(done), .seq_state(st)
    );

    ctech_lib_rstb_sequencer #(.SYNC_STAGES(2), .NUM_RST(1), .STAGE_DLY(1)) u_dut1 (
        .clk(clk), .rb(rb1), .sw_rst_req(req1), .sw_rst_ack(ack1),
        .rst_out_b(rst_b1), .rst_done(done1), .seq_state(st1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [6:0] v(input logic a, input logic d, input logic [1:0] s,
                                     input logic [2:0] r);
        return {a, d, s, r};
    endfunction

    task automatic push_ev(input int c, input logic [6:0] vec);
        ev_t e;
        e.cyc = c;
        e.vec = vec;
        sb_q.push_back(e);
    endtask

    // b is the edge on which the FSM enters RELEASE
    task automatic push_release(input int b);
        push_ev(b,      v(1'b0, 1'b0, 2'd1, 3'b000));
        push_ev(b + 8,  v(1'b0, 1'b0, 2'd1, 3'b001));
        push_ev(b + 16, v(1'b0, 1'b0, 2'd1, 3'b011));
        push_ev(b + 24, v(1'b0, 1'b1, 2'd2, 3'b111));
    endtask

    always @(posedge clk) begin : mon
        logic [6:0] cur;
        ev_t        ev;
        #1;
        cur = {ack, done, st, rst_b};
        if (mon_en && cur !== prev) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_change", 32'(cur), 32'(prev));
            end else begin
                ev = sb_q.pop_front();
                chk("event_cycle", cyc, ev.cyc);
                chk("event_value", 32'(cur), 32'(ev.vec));
            end
        end
        prev = cur;
    end

    task automatic wait_drain(input string tag, input int lim);
        for (int i = 0; i < lim && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk({"drain_", tag}, sb_q.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rst_out_b"}, rst_b, 0);
        chk({tag, "_rst_done"}, done, 0);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_state"}, st, 0);
    endtask

    task automatic rb_rise(output int e0);
        mon_en = 1'b0;
        rb = 1'b1;
        e0 = cyc + 1;
        @(posedge clk);
        #2;
        mon_en = 1'b1;
    endtask

    task automatic rb_pulse(input string tag, output int e0);
        mon_en = 1'b0;
        @(negedge clk);
        #1 rb = 1'b0;
        #1 check_reset(tag);
        #2;
        sb_q.delete();
        rb_rise(e0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e0, e, f;
        rb = 1'b0; req = 1'b0; rb1 = 1'b0; req1 = 1'b0;

        repeat (5) @(negedge clk);
        check_reset("por");
        rb_rise(e0);
        push_release(e0 + 2);
        wait_drain("por", 60);

        @(negedge clk);
        req = 1'b1;
        e = cyc + 1;
        push_ev(e,     v(1'b0, 1'b0, 2'd3, 3'b000));
        push_ev(e + 8, v(1'b1, 1'b0, 2'd3, 3'b000));
        wait_drain("swrst_ack", 20);
        repeat (4) @(negedge clk);
        req = 1'b0;
        f = cyc + 1;
        push_release(f);
        wait_drain("swrst_rel", 40);

        @(negedge clk);
        req = 1'b1;
        e = cyc + 1;
        push_ev(e,     v(1'b0, 1'b0, 2'd3, 3'b000));
        push_ev(e + 8, v(1'b1, 1'b0, 2'd3, 3'b000));
        push_release(e + 9);
        repeat (3) @(negedge clk);
        req = 1'b0;
        wait_drain("early_drop", 50);

        rb_pulse("done_glitch", e0);
        push_release(e0 + 2);
        repeat (12) @(negedge clk);
        chk("mid_release_rst_out_b", rst_b, 3'b001);
        chk("mid_release_state", st, 1);
        rb_pulse("rel_glitch", e0);
        push_release(e0 + 2);
        wait_drain("glitch_rerun", 60);

        mon_en = 1'b0;
        @(negedge clk);
        rb = 1'b0;
        #1 check_reset("rb_hold");
        req = 1'b1;
        repeat (3) @(negedge clk);
        rb_rise(e0);
        push_release(e0 + 2);
        push_ev(e0 + 27, v(1'b0, 1'b0, 2'd3, 3'b000));
        push_ev(e0 + 35, v(1'b1, 1'b0, 2'd3, 3'b000));
        wait_drain("req_early", 80);
        @(negedge clk);
        req = 1'b0;
        f = cyc + 1;
        push_release(f);
        wait_drain("req_early_rel", 40);

        chk("n1_reset_rst", rst_b1, 0);
        chk("n1_reset_done", done1, 0);
        @(negedge clk);
        rb1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("n1_held_rst", rst_b1, 0);
        end
        @(posedge clk);
        #1;
        chk("n1_rel_rst", rst_b1, 1);
        chk("n1_rel_done", done1, 1);
        chk("n1_rel_state", st1, 2);
        @(negedge clk);
        #1 rb1 = 1'b0;
        #1;
        chk("n1_async_rst", rst_b1, 0);
        chk("n1_async_done", done1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
